// File: rtl/aes_pkg.sv
// Shared AES decryption constants, FSM encoding, inverse S-box and GF(2^8) multiply helpers.
// Pure declarations: no state, no latency, no flow control.
package aes_pkg;

  localparam int NR    = 10;
  localparam int KEY_W = 128 * (NR + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gmul11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gmul13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gmul14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round, purely combinational: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless last. Zero latency, no flow control.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         last,
  output logic [127:0] state_out
);

  logic [7:0] ak [16];
  logic [7:0] mc [16];

  // Byte (row r, col c) sits at index 4*c+r; rows rotate right by r.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        ak[4*c+r] = INV_SBOX[state_in[127-8*(4*((c-r+4)%4)+r) -: 8]]
                    ^ round_key[127-8*(4*c+r) -: 8];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      mc[4*c+0] = gmul14(ak[4*c]) ^ gmul11(ak[4*c+1]) ^ gmul13(ak[4*c+2]) ^ gmul9(ak[4*c+3]);
      mc[4*c+1] = gmul9(ak[4*c])  ^ gmul14(ak[4*c+1]) ^ gmul11(ak[4*c+2]) ^ gmul13(ak[4*c+3]);
      mc[4*c+2] = gmul13(ak[4*c]) ^ gmul9(ak[4*c+1])  ^ gmul14(ak[4*c+2]) ^ gmul11(ak[4*c+3]);
      mc[4*c+3] = gmul11(ak[4*c]) ^ gmul13(ak[4*c+1]) ^ gmul9(ak[4*c+2])  ^ gmul14(ak[4*c+3]);
    end
  end

  always_comb begin
    state_out = '0;
    for (int i = 0; i < 16; i++) begin
      state_out[127-8*i -: 8] = last ? ak[i] : mc[i];
    end
  end

endmodule

// File: rtl/aes_decrypt_iterative.sv
// Iterative AES-128 decryptor, one inverse round per clock; out_valid 10 edges after accept.
// Accepts only in IDLE; result held in DONE until out_ready, so block period is 12 cycles minimum.
module aes_decrypt_iterative #(
  parameter int NR    = aes_pkg::NR,
  parameter int KEY_W = aes_pkg::KEY_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_W-1:0]   expanded_key,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       cipher_text,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       plain_text,
  output logic               busy
);

  import aes_pkg::state_e;
  import aes_pkg::IDLE;
  import aes_pkg::ROUND;
  import aes_pkg::DONE;

  state_e       state_q, state_d;
  logic [3:0]   round_cnt_q, round_cnt_d;
  logic [127:0] data_q, data_d;
  logic [127:0] rk [NR+1];
  logic [3:0]   key_idx;
  logic [127:0] round_key;
  logic [127:0] round_out;

  for (genvar r = 0; r <= NR; r++) begin : g_rk
    assign rk[r] = expanded_key[KEY_W-1-128*r -: 128];
  end

  // The accept edge whitens with the last round key; rounds then walk down to key 0.
  assign key_idx   = (state_q == IDLE) ? 4'(NR) : round_cnt_q;
  assign round_key = rk[key_idx];

  aes_inv_round u_round (
    .state_in  (data_q),
    .round_key (round_key),
    .last      (round_cnt_q == 4'd0),
    .state_out (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)                state_d = ROUND;
      ROUND:   if (round_cnt_q == 4'd0)     state_d = DONE;
      DONE:    if (out_ready)               state_d = IDLE;
      default:                              state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  always_comb begin
    data_d      = data_q;
    round_cnt_d = round_cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d      = cipher_text ^ round_key;
          round_cnt_d = 4'(NR - 1);
        end
      end
      ROUND: begin
        data_d = round_out;
        if (round_cnt_q != 4'd0) round_cnt_d = round_cnt_q - 4'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q      <= '0;
      round_cnt_q <= '0;
    end else begin
      data_q      <= data_d;
      round_cnt_q <= round_cnt_d;
    end
  end

  assign plain_text = data_q;

endmodule

// File: tb/tb_aes_decrypt_iterative.sv
// Directed and round-trip bench for aes_decrypt_iterative; key schedule and forward cipher
// are modelled here from a GF(2^8)-derived S-box.
module tb_aes_decrypt_iterative;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1407:0]   expanded_key;
  logic            in_valid;
  logic            in_ready;
  logic [127:0]    cipher_text;
  logic            out_valid;
  logic            out_ready;
  logic [127:0]    plain_text;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0] fs [256];

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam int NSTREAM = 20;

  aes_decrypt_iterative dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .expanded_key (expanded_key),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .cipher_text  (cipher_text),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .plain_text   (plain_text),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc = 8'h01;
    logic [1407:0] e;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {fs[t[31:24]], fs[t[23:16]], fs[t[15:8]], fs[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) e[1407-32*i -: 32] = w[i];
    return e;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [1407:0] ek);
    logic [127:0] s, o;
    logic [7:0]   a0, a1, a2, a3;
    s = pt ^ ek[1407 -: 128];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = fs[s[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          o[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
      s = o;
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[127-32*c -: 8];    a1 = s[119-32*c -: 8];
          a2 = s[111-32*c -: 8];    a3 = s[103-32*c -: 8];
          o[127-32*c -: 8] = gm(a0, 2) ^ gm(a1, 3) ^ a2 ^ a3;
          o[119-32*c -: 8] = a0 ^ gm(a1, 2) ^ gm(a2, 3) ^ a3;
          o[111-32*c -: 8] = a0 ^ a1 ^ gm(a2, 2) ^ gm(a3, 3);
          o[103-32*c -: 8] = gm(a0, 3) ^ a1 ^ a2 ^ gm(a3, 2);
        end
        s = o;
      end
      s = s ^ ek[1407-128*r -: 128];
    end
    return s;
  endfunction

  task automatic send(input logic [127:0] ct);
    int n = 0;
    @(negedge clk);
    in_valid    = 1'b1;
    cipher_text = ct;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(input int start, output int lat);
    lat = start;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!out_valid && lat < 60);
    check("out_valid_seen", out_valid, 1'b1);
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("idle_after_handshake", {out_valid, in_ready, busy}, 3'b010);
  endtask

  initial begin
    int lat;
    int n;
    int acc [NSTREAM];
    logic [127:0] pts [NSTREAM];
    logic [127:0] cts [NSTREAM];
    logic [7:0] inv;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      fs[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    rst_n        = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    cipher_text  = '0;
    expanded_key = expand(KEY_C1);
    repeat (2) @(negedge clk);
    check("reset_flags", {in_ready, out_valid, busy}, 3'b100);
    check("reset_pt", plain_text, '0);
    rst_n = 1'b1;

    // FIPS-197 C.1 with exact latency
    send(CT_C1);
    check("busy_in_round", busy, 1'b1);
    wait_out(0, lat);
    check("c1_latency", lat, 10);
    check("c1_pt", plain_text, PT_C1);
    check("done_in_ready", in_ready, 1'b0);
    drain();

    // FIPS-197 App.B under 5 cycles of backpressure
    expanded_key = expand(KEY_B);
    send(CT_B);
    wait_out(0, lat);
    check("b_latency", lat, 10);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_pt", plain_text, PT_B);
      check("bp_hold_flags", {out_valid, in_ready}, 2'b10);
    end
    drain();

    // Second block offered mid-decrypt must be dropped
    expanded_key = expand(KEY_C1);
    send(CT_C1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    in_valid    = 1'b1;
    cipher_text = CT_B;
    check("busy_drop_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_out(4, lat);
    check("busy_drop_latency", lat, 10);
    check("busy_drop_pt", plain_text, PT_C1);
    drain();
    expanded_key = expand(KEY_B);
    send(CT_B);
    wait_out(0, lat);
    check("represent_pt", plain_text, PT_B);
    drain();

    // Reset with round_cnt at 5
    expanded_key = expand(KEY_C1);
    send(CT_C1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_flags", {in_ready, out_valid, busy}, 3'b100);
    check("midreset_pt", plain_text, '0);
    @(negedge clk);
    rst_n = 1'b1;
    send(CT_C1);
    wait_out(0, lat);
    check("post_reset_latency", lat, 10);
    check("post_reset_pt", plain_text, PT_C1);
    drain();

    // Random round trips through the bench-side encryptor, out_ready tied high
    expanded_key = expand(KEY_B);
    for (int i = 0; i < NSTREAM; i++) begin
      pts[i] = {$urandom, $urandom, $urandom, $urandom};
      cts[i] = encrypt(pts[i], expanded_key);
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid    = 1'b1;
    cipher_text = cts[0];
    for (int i = 0; i < NSTREAM; i++) begin
      n = 0;
      while (!in_ready && n < 40) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk);
      #1 acc[i] = cyc;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("stream_pt", plain_text, pts[i]);
      if (i > 0) check("stream_spacing", acc[i] - acc[i-1], 12);
      if (i < NSTREAM - 1) cipher_text = cts[i+1];
      else in_valid = 1'b0;
    end
    @(negedge clk);
    out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
